m_fetch_unit: RTL
=================

# m_fetch_unit

Instruction-fetch stage sitting directly downstream of `m_PC_selector`. It owns the architectural PC register (`pc_ff`) and computes `pc_plus_4`, both of which feed the selector. It loads `pc_next` from the selector on redirects and completed fetches. It issues one outstanding request at a time to instruction memory over a req/ack handshake and presents the fetched word to decode through a one-entry valid/ready buffer.

## Interface
Parameters:
- `RESET_PC`, `32'h8000_0000`: value of `pc_ff` out of reset.
- `XLEN`, `32`: address and data width.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `pc_next`  in  XLEN  next PC from `m_PC_selector`.
- `redirect`  in  1  `csr_new_pc_req | exe_new_pc_req`; flush and load `pc_next`.
- `wfi_req`  in  1  while high, no new fetch is launched.
- `pc_ff`  out  XLEN  current fetch PC.
- `pc_plus_4`  out  XLEN  `pc_ff + 4`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  registered request address.
- `imem_ack`  in  1  response valid; may arrive 1..N cycles after `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `imem_err`  in  1  access fault, valid with `imem_ack`.
- `if_valid`  out  1  buffered instruction available.
- `if_ready`  in  1  decode accepts.
- `if_instr`  out  32  instruction.
- `if_pc`  out  XLEN  PC of `if_instr`.
- `if_cause`  out  2  0 = none, 1 = access fault, 2 = misaligned.

## Operation
- FSM states:
  - `IDLE`: no request.
  - `REQ`: `imem_req=1`; `imem_addr` is held stable until `imem_ack`.
  - `DRAIN`: the request is still outstanding after a redirect; the response will be discarded.
  - `HOLD`: the buffer is full and waits for `if_ready`.
- `pc_plus_4 = pc_ff + 4`, truncated to XLEN. Wrap from `FFFF_FFFC` to `0000_0000` is legal and unflagged.
- `pc_ff` loads `pc_next` only in these cycles:
  - any cycle with `redirect=1`;
  - a `REQ` cycle with `imem_ack=1` and `redirect=0`.
- In all other cycles `pc_ff` holds.
- Transitions:
  - `IDLE`→`REQ` when `wfi_req=0`. On launch, `imem_addr` is loaded from `pc_ff`.
  - `REQ` with ack and no redirect → `HOLD`. The buffer loads `instr=imem_rdata`, `pc=imem_addr`, and `cause = imem_err ? 1 : 0`.
  - `REQ` with ack and redirect → `IDLE`; the data is discarded.
  - `REQ` with redirect and no ack → `DRAIN`.
  - `DRAIN` with ack → `IDLE`; the data is discarded. A further redirect while in `DRAIN` only updates `pc_ff`.
  - `HOLD` with `if_ready` → `IDLE`.
  - `HOLD` with redirect → `IDLE`; the buffer is invalidated. Redirect wins over `if_ready`.
- `wfi_req` blocks only the `IDLE`→`REQ` launch. It never aborts an outstanding request.
- Reset mid-request: `imem_req` drops in the next cycle and any later stray `imem_ack` is ignored. The memory side must tolerate the dropped request.

## Timing
- Reset values:
  - `pc_ff=RESET_PC`, `pc_plus_4=RESET_PC+4`;
  - state `IDLE`, `imem_req=0`, `imem_addr=0`;
  - `if_valid=0`, `if_instr=0`, `if_pc=0`, `if_cause=0`.
- First cycle after `rst_n` rises: state is `IDLE`. Next cycle: `imem_req=1`, `imem_addr=RESET_PC`.
- Ack in cycle N: `if_valid=1` in N+1, and `pc_ff` holds the new value in N+1.
- Decode accept in cycle M: `if_valid=0` in M+1 and `imem_req=1` in M+2 (absent wfi).
- Peak throughput: one instruction per 3 cycles with single-cycle ack.
- Redirect in cycle R: `if_valid=0` and `pc_ff=pc_next` in R+1. The first request to the target launches no earlier than R+2; in `DRAIN` it launches after the discarded ack.
- All outputs are registered except `pc_plus_4`, which is combinational from `pc_ff`.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - At the `IDLE`→`REQ` decision, if `pc_ff[1:0]!=0`, no memory request is issued.
  - The state goes directly to `HOLD` with `if_instr=0`, `if_pc=pc_ff`, `if_cause=2`.
  - `pc_ff` holds and waits for the redirect.
- `FETCH_MISALIGN_CHK_EN` undefined:
  - `imem_addr = {pc_ff[XLEN-1:2],2'b00}`.
  - Cause 2 is never produced.

## Structure
- `fetch_pkg` holds:
  - the `fetch_state_e` enum;
  - the `fetch_cause_e` enum (NONE, ACCESS_FAULT, MISALIGNED);
  - the default `RESET_PC` constant.
- Sub-module `m_fetch_buffer`: the one-entry instr/pc/cause register with load, pop and flush.
- The FSM, PC register and memory interface stay in `m_fetch_unit`.

## Test plan
- Reset release with single-cycle ack and `if_ready=1` → addresses `8000_0000`, `8000_0004`, `8000_0008` are issued. `if_pc` follows the same sequence, with `if_instr` equal to the acked data.
- Redirect to `0000_1000` during a 3-cycle-latency outstanding fetch of `8000_0004` → `DRAIN`; that data never reaches `if_valid`. The next `imem_addr` is `0000_1000`.
- Redirect with `if_valid=1` and `if_ready=1` in the same cycle → the instruction is not counted as accepted and `if_valid=0` in the next cycle.
- `wfi_req=1` while in `HOLD`, then pop → no `imem_req` until `wfi_req` falls. Then `imem_req=1` one cycle later with address `pc_ff`.
- `imem_err=1` on the fetch of `8000_0010` → `if_valid=1`, `if_cause=1`, `if_pc=8000_0010`.
- With `FETCH_MISALIGN_CHK_EN` defined, redirect to `8000_0002` → no `imem_req`; `if_cause=2`, `if_pc=8000_0002`. With the macro undefined, `imem_addr=8000_0000`.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        ACCESS_FAULT = 2'd1,
        MISALIGNED   = 2'd2
    } fetch_cause_e;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if : instruction-memory req/ack bus plus the decode valid/ready bus
// Revision : 1.0
// ============================================================================
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            imem_err;

    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [1:0]      if_cause;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, imem_err,
        output if_valid, if_instr, if_pc, if_cause,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, imem_err,
        input  if_valid, if_instr, if_pc, if_cause,
        output if_ready
    );
endinterface
`default_nettype wire

// File: rtl/m_fetch_buffer.sv
`default_nettype none
// ============================================================================
// m_fetch_buffer : one-entry instr/pc/cause register with load, pop and flush
// Revision       : 1.0
// ============================================================================
module m_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_load,
    input  wire logic            i_pop,
    input  wire logic            i_flush,
    input  wire logic [31:0]     i_instr,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [1:0]      i_cause,
    output logic                 o_valid,
    output logic      [31:0]     o_instr,
    output logic      [XLEN-1:0] o_pc,
    output logic      [1:0]      o_cause
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [1:0]      cause_q, cause_d;

    // Flush dominates so a redirect always empties the entry.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            instr_d = i_instr;
            pc_d    = i_pc;
            cause_d = i_cause;
        end else if (i_pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            cause_q <= NONE;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;
    assign o_cause = cause_q;

endmodule
`default_nettype wire

// File: rtl/m_fetch_unit.sv
`default_nettype none
// ============================================================================
// m_fetch_unit : PC register, single-outstanding imem fetch FSM, decode buffer
// Option       : FETCH_MISALIGN_CHK_EN traps misaligned PCs without fetching
// Revision     : 1.0
// ============================================================================
module m_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [XLEN-1:0] pc_next,
    input  wire logic            redirect,
    input  wire logic            wfi_req,
    output logic      [XLEN-1:0] pc_ff,
    output logic      [XLEN-1:0] pc_plus_4,
    fetch_if.master              bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;

    logic            w_ack_live;
    logic            w_launch_ok;
    logic            w_misalign;
    logic            buf_load, buf_pop;
    logic [31:0]     buf_instr;
    logic [XLEN-1:0] buf_pc;
    fetch_cause_e    buf_cause;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_misalign = (pc_q[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // No launch in a redirect cycle: pc_q still holds the stale target then.
    assign w_ack_live  = (state_q == ST_REQ) && bus.imem_ack;
    assign w_launch_ok = (state_q == ST_IDLE) && !wfi_req && !redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_launch_ok) state_d = w_misalign ? ST_HOLD : ST_REQ;
            ST_REQ: begin
                if (bus.imem_ack)  state_d = redirect ? ST_IDLE : ST_HOLD;
                else if (redirect) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (bus.imem_ack) state_d = ST_IDLE;
            ST_HOLD:  if (redirect || bus.if_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The request stays asserted through DRAIN so the memory sees a full handshake.
    always_comb begin
        pc_d      = (redirect || w_ack_live) ? pc_next : pc_q;
        req_d     = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        addr_d    = addr_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            addr_d = {pc_q[XLEN-1:2], 2'b00};
        end
        buf_load  = (w_ack_live && !redirect) || (w_launch_ok && w_misalign);
        buf_pop   = (state_q == ST_HOLD) && bus.if_ready;
        buf_instr = bus.imem_rdata;
        buf_pc    = addr_q;
        buf_cause = bus.imem_err ? ACCESS_FAULT : NONE;
        if (state_q == ST_IDLE) begin
            buf_instr = '0;
            buf_pc    = pc_q;
            buf_cause = MISALIGNED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            addr_q <= '0;
            req_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            req_q  <= req_d;
        end
    end

    m_fetch_buffer #(
        .XLEN (XLEN)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (buf_load),
        .i_pop   (buf_pop),
        .i_flush (redirect),
        .i_instr (buf_instr),
        .i_pc    (buf_pc),
        .i_cause (buf_cause),
        .o_valid (bus.if_valid),
        .o_instr (bus.if_instr),
        .o_pc    (bus.if_pc),
        .o_cause (bus.if_cause)
    );

    assign pc_ff         = pc_q;
    assign pc_plus_4     = pc_q + XLEN'(4);
    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;

endmodule
`default_nettype wire
